sram128x8_ctrl: RTL and testbench

- Single-port initiator for the gf180mcu_fd_ip_sram__sram128x8m8wm1 macro: turns a valid/ready request stream into the macro's active-low CEN/GWEN/WEN strobes and returns read data on a valid/ready response channel.
- Sits between a core-side requester and the SRAM instance; the SRAM is the responder, this block is the initiator.
- One access outstanding at a time; all SRAM-facing outputs are registered.

---
 rtl/sram_ctrl_pkg.sv | 10 +
 rtl/sram128x8_ctrl_if.sv | 26 ++
 rtl/sram128x8_ctrl.sv | 138 +++++++++++++
 tb/tb_sram128x8_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared state encoding, macro geometry and idle strobe levels
// for the sram128x8 controller.
package sram_ctrl_pkg;
    localparam int SRAM_ADDR_W = 7;
    localparam int SRAM_DATA_W = 8;
    typedef enum logic [2:0] {INIT, IDLE, ISSUE, CAPTURE, RESP} state_t;
    localparam logic CEN_OFF = 1'b1;
    localparam logic GWEN_OFF = 1'b1;
    localparam logic [SRAM_DATA_W-1:0] WEN_OFF = '1;
endpackage

// File: rtl/sram128x8_ctrl_if.sv
// sram128x8_ctrl_if: request/response channel between a core-side requester (master)
// and the SRAM controller (slave).
interface sram128x8_ctrl_if
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W = SRAM_ADDR_W,
    parameter int DATA_W = SRAM_DATA_W
);
    logic              REQ_VALID;
    logic              REQ_READY;
    logic              REQ_WRITE;
    logic [ADDR_W-1:0] REQ_ADDR;
    logic [DATA_W-1:0] REQ_WDATA;
    logic [DATA_W-1:0] REQ_WMASK;
    logic              RSP_VALID;
    logic              RSP_READY;
    logic [DATA_W-1:0] RSP_RDATA;
    modport master (
        output REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_WDATA, REQ_WMASK, RSP_READY,
        input  REQ_READY, RSP_VALID, RSP_RDATA
    );
    modport slave (
        input  REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_WDATA, REQ_WMASK, RSP_READY,
        output REQ_READY, RSP_VALID, RSP_RDATA
    );
endinterface

// File: rtl/sram128x8_ctrl.sv
// sram128x8_ctrl: valid/ready initiator driving the gf180mcu sram128x8 macro strobes.
// Define SRAM_INIT_EN to sweep INIT_VALUE into every word after reset and expose INIT_DONE.
module sram128x8_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W = SRAM_ADDR_W,
    parameter int DATA_W = SRAM_DATA_W
`ifdef SRAM_INIT_EN
    ,
    parameter logic [DATA_W-1:0] INIT_VALUE = '0
`endif
) (
    input  logic              CLK,
    input  logic              RST,
    sram128x8_ctrl_if.slave   bus,
    output logic              CEN,
    output logic              GWEN,
    output logic [DATA_W-1:0] WEN,
    output logic [ADDR_W-1:0] A,
    output logic [DATA_W-1:0] D,
    input  logic [DATA_W-1:0] Q
`ifdef SRAM_INIT_EN
    ,
    output logic              INIT_DONE
`endif
);
`ifdef SRAM_INIT_EN
    localparam state_t RST_STATE = INIT;
    logic [ADDR_W-1:0] cnt, cnt_n;
    logic sweep, sweep_n, done, done_n;
    assign INIT_DONE = done;
`else
    localparam state_t RST_STATE = IDLE;
`endif
    state_t state, state_n;
    logic rdy, rdy_n, wr, wr_n, rsp_v, rsp_v_n, cen_n, gwen_n, acc;
    logic [DATA_W-1:0] rdata, rdata_n, wen_n, d_n;
    logic [ADDR_W-1:0] a_n;
    // rdy is registered so it stays low for the first cycle out of reset
    assign acc = bus.REQ_VALID && rdy;
    assign bus.REQ_READY = rdy;
    assign bus.RSP_VALID = rsp_v;
    assign bus.RSP_RDATA = rdata;
    always_comb begin
        state_n = state;
        wr_n = wr;
        rsp_v_n = rsp_v;
        rdata_n = rdata;
        cen_n = CEN_OFF;
        gwen_n = GWEN_OFF;
        wen_n = WEN_OFF;
        a_n = A;
        d_n = D;
`ifdef SRAM_INIT_EN
        cnt_n = cnt;
        sweep_n = sweep;
        done_n = done;
`endif
        case (state)
`ifdef SRAM_INIT_EN
            INIT: begin
                state_n = ISSUE;
                wr_n = 1'b1;
                cen_n = 1'b0;
                gwen_n = 1'b0;
                wen_n = ~WEN_OFF;
                a_n = cnt;
                d_n = INIT_VALUE;
            end
`endif
            IDLE: if (acc) begin
                state_n = ISSUE;
                wr_n = bus.REQ_WRITE;
                cen_n = 1'b0;
                gwen_n = !bus.REQ_WRITE;
                wen_n = bus.REQ_WRITE ? ~bus.REQ_WMASK : WEN_OFF;
                a_n = bus.REQ_ADDR;
                d_n = bus.REQ_WDATA;
            end
            ISSUE: begin
`ifdef SRAM_INIT_EN
                state_n = sweep ? (cnt == '1 ? IDLE : INIT) : wr ? IDLE : CAPTURE;
                cnt_n = sweep && cnt != '1 ? cnt + 1'b1 : cnt;
                sweep_n = sweep && cnt != '1;
                done_n = done || (sweep && cnt == '1);
`else
                state_n = wr ? IDLE : CAPTURE;
`endif
            end
            CAPTURE: begin
                rdata_n = Q;
                rsp_v_n = 1'b1;
                state_n = RESP;
            end
            RESP: if (bus.RSP_READY) begin
                rsp_v_n = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        rdy_n = state_n == IDLE;
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= RST_STATE;
            rdy <= 1'b0;
            wr <= 1'b0;
            rsp_v <= 1'b0;
            rdata <= '0;
            CEN <= CEN_OFF;
            GWEN <= GWEN_OFF;
            WEN <= WEN_OFF;
            A <= '0;
            D <= '0;
`ifdef SRAM_INIT_EN
            cnt <= '0;
            sweep <= 1'b1;
            done <= 1'b0;
`endif
        end else begin
            state <= state_n;
            rdy <= rdy_n;
            wr <= wr_n;
            rsp_v <= rsp_v_n;
            rdata <= rdata_n;
            CEN <= cen_n;
            GWEN <= gwen_n;
            WEN <= wen_n;
            A <= a_n;
            D <= d_n;
`ifdef SRAM_INIT_EN
            cnt <= cnt_n;
            sweep <= sweep_n;
            done <= done_n;
`endif
        end
    end
endmodule

// File: tb/tb_sram128x8_ctrl.sv
// tb_sram128x8_ctrl: randomized self-checking bench against a word-level memory model.
// Honours SRAM_INIT_EN (init sweep checks and INIT_DONE port).
module tb_sram128x8_ctrl;
    logic CLK = 0, RST = 1;
    logic CEN, GWEN;
    logic [7:0] WEN, D, Q;
    logic [6:0] A;
`ifdef SRAM_INIT_EN
    logic INIT_DONE;
`endif
    logic [7:0] sram [128];
    logic [7:0] ref_mem [128];
    bit known [128];
    int n_cmp = 0, n_bad = 0;

    sram128x8_ctrl_if bus ();

    sram128x8_ctrl dut (
        .CLK(CLK), .RST(RST), .bus(bus),
        .CEN(CEN), .GWEN(GWEN), .WEN(WEN), .A(A), .D(D), .Q(Q)
`ifdef SRAM_INIT_EN
        , .INIT_DONE(INIT_DONE)
`endif
    );

    always #5 CLK = ~CLK;

    // behavioural macro: per-bit write when GWEN low, registered read otherwise
    always @(posedge CLK)
        if (!CEN) begin
            if (!GWEN) sram[A] <= (sram[A] & WEN) | (D & ~WEN);
            else Q <= sram[A];
        end

    task automatic post_reset();
`ifdef SRAM_INIT_EN
        for (int i = 0; i < 128; i++) begin ref_mem[i] = 8'h00; known[i] = 1; end
        repeat (300) @(negedge CLK);
`endif
    endtask

    task automatic do_reset();
        RST = 1; bus.REQ_VALID = 0; bus.RSP_READY = 0;
        repeat (2) @(negedge CLK);
        RST = 0;
        post_reset();
    endtask

    task automatic do_write(input logic [6:0] a, input logic [7:0] d, input logic [7:0] m,
                            output int cen_lo, output logic [7:0] wen_s, output logic gwen_s);
        int t = 0;
        bus.REQ_VALID = 1; bus.REQ_WRITE = 1; bus.REQ_ADDR = a; bus.REQ_WDATA = d; bus.REQ_WMASK = m;
        while (!bus.REQ_READY && t < 50) begin @(negedge CLK); t++; end
        @(negedge CLK);
        bus.REQ_VALID = 0;
        cen_lo = 0; wen_s = 8'hFF; gwen_s = 1;
        repeat (3) begin
            if (!CEN) begin cen_lo++; wen_s = WEN; gwen_s = GWEN; end
            @(negedge CLK);
        end
        if (t < 50) begin ref_mem[a] = (ref_mem[a] & ~m) | (d & m); known[a] = 1; end
    endtask

    task automatic do_read(input logic [6:0] a, output logic [7:0] data, output int lat, output int cen_lo);
        int t = 0;
        bus.REQ_VALID = 1; bus.REQ_WRITE = 0; bus.REQ_ADDR = a;
        bus.REQ_WDATA = 8'($urandom); bus.REQ_WMASK = 8'($urandom);
        while (!bus.REQ_READY && t < 50) begin @(negedge CLK); t++; end
        @(negedge CLK);
        bus.REQ_VALID = 0;
        lat = 0; cen_lo = 0; data = 8'hxx;
        while (!bus.RSP_VALID && lat < 20) begin
            if (!CEN) cen_lo++;
            @(negedge CLK); lat++;
        end
        data = bus.RSP_RDATA;
        bus.RSP_READY = 1;
        @(negedge CLK);
        bus.RSP_READY = 0;
    endtask

    task automatic test_reset();
        RST = 1; bus.REQ_VALID = 0; bus.RSP_READY = 0;
        repeat (2) @(negedge CLK);
        n_cmp++; if (CEN !== 1'b1) begin n_bad++; $display("FAIL reset_cen: got %b expected 1", CEN); end
        n_cmp++; if (GWEN !== 1'b1) begin n_bad++; $display("FAIL reset_gwen: got %b expected 1", GWEN); end
        n_cmp++; if (WEN !== 8'hFF) begin n_bad++; $display("FAIL reset_wen: got %h expected ff", WEN); end
        n_cmp++; if (A !== 7'h00) begin n_bad++; $display("FAIL reset_a: got %h expected 00", A); end
        n_cmp++; if (D !== 8'h00) begin n_bad++; $display("FAIL reset_d: got %h expected 00", D); end
        n_cmp++; if (bus.REQ_READY !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b expected 0", bus.REQ_READY); end
        n_cmp++; if (bus.RSP_VALID !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.RSP_VALID); end
        n_cmp++; if (bus.RSP_RDATA !== 8'h00) begin n_bad++; $display("FAIL reset_rdata: got %h expected 00", bus.RSP_RDATA); end
        RST = 0;
        @(negedge CLK);
`ifdef SRAM_INIT_EN
        n_cmp++; if (bus.REQ_READY !== 1'b0) begin n_bad++; $display("FAIL reset_ready_init: got %b expected 0", bus.REQ_READY); end
        n_cmp++; if (INIT_DONE !== 1'b0) begin n_bad++; $display("FAIL reset_init_done: got %b expected 0", INIT_DONE); end
`else
        n_cmp++; if (bus.REQ_READY !== 1'b1) begin n_bad++; $display("FAIL reset_ready_idle: got %b expected 1", bus.REQ_READY); end
`endif
        post_reset();
    endtask

`ifdef SRAM_INIT_EN
    task automatic test_init();
        int c = 0, rdy_hi = 0, lows = 0, lat, cl;
        logic [7:0] q;
        RST = 1; bus.REQ_VALID = 1; bus.REQ_WRITE = 0; bus.REQ_ADDR = 7'h3C;
        repeat (2) @(negedge CLK);
        RST = 0;
        while (!INIT_DONE && c < 400) begin
            if (bus.REQ_READY) rdy_hi++;
            if (!CEN) begin
                lows++;
                n_cmp++; if (WEN !== 8'h00 || GWEN !== 1'b0 || D !== 8'h00) begin n_bad++; $display("FAIL init_strobe: got wen=%h gwen=%b d=%h expected 00/0/00", WEN, GWEN, D); end
            end
            @(negedge CLK); c++;
        end
        bus.REQ_VALID = 0;
        for (int i = 0; i < 128; i++) begin ref_mem[i] = 8'h00; known[i] = 1; end
        n_cmp++; if (c !== 256) begin n_bad++; $display("FAIL init_cycles: got %0d expected 256", c); end
        n_cmp++; if (lows !== 128) begin n_bad++; $display("FAIL init_writes: got %0d expected 128", lows); end
        n_cmp++; if (rdy_hi !== 0) begin n_bad++; $display("FAIL init_ready_low: got %0d ready cycles expected 0", rdy_hi); end
        n_cmp++; if (bus.REQ_READY !== 1'b1) begin n_bad++; $display("FAIL init_ready_after: got %b expected 1", bus.REQ_READY); end
        do_read(7'h3C, q, lat, cl);
        n_cmp++; if (q !== 8'h00) begin n_bad++; $display("FAIL init_read_3c: got %h expected 00", q); end
    endtask
`endif

    task automatic test_basic();
        int cl, lat; logic [7:0] w, q; logic g;
        do_write(7'h05, 8'hA5, 8'hFF, cl, w, g);
        n_cmp++; if (cl !== 1) begin n_bad++; $display("FAIL basic_wr_cen: got %0d low cycles expected 1", cl); end
        n_cmp++; if (w !== 8'h00 || g !== 1'b0) begin n_bad++; $display("FAIL basic_wr_strobe: got wen=%h gwen=%b expected 00/0", w, g); end
        do_read(7'h05, q, lat, cl);
        n_cmp++; if (q !== ref_mem[5]) begin n_bad++; $display("FAIL basic_rd_data: got %h expected %h", q, ref_mem[5]); end
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL basic_rd_latency: got %0d expected 2", lat); end
        n_cmp++; if (cl !== 1) begin n_bad++; $display("FAIL basic_rd_cen: got %0d low cycles expected 1", cl); end
    endtask

    task automatic test_mask();
        int cl, lat; logic [7:0] w, q; logic g;
        do_write(7'h10, 8'hFF, 8'hFF, cl, w, g);
        do_write(7'h10, 8'h00, 8'h0F, cl, w, g);
        n_cmp++; if (w !== 8'hF0 || g !== 1'b0) begin n_bad++; $display("FAIL mask_strobe: got wen=%h gwen=%b expected f0/0", w, g); end
        do_read(7'h10, q, lat, cl);
        n_cmp++; if (q !== 8'hF0) begin n_bad++; $display("FAIL mask_read: got %h expected f0", q); end
        do_write(7'h20, 8'h5A, 8'hFF, cl, w, g);
        do_write(7'h20, 8'hA5, 8'h00, cl, w, g);
        n_cmp++; if (cl !== 1 || w !== 8'hFF || g !== 1'b0) begin n_bad++; $display("FAIL mask0_strobe: got cen_lo=%0d wen=%h gwen=%b expected 1/ff/0", cl, w, g); end
        do_read(7'h20, q, lat, cl);
        n_cmp++; if (q !== 8'h5A) begin n_bad++; $display("FAIL mask0_read: got %h expected 5a", q); end
    endtask

    task automatic test_stall();
        int t = 0;
        logic [7:0] exp_q = ref_mem[5];
        bus.REQ_VALID = 1; bus.REQ_WRITE = 0; bus.REQ_ADDR = 7'h05;
        while (!bus.REQ_READY && t < 50) begin @(negedge CLK); t++; end
        @(negedge CLK);
        // a competing write stays pending while the response is stalled
        bus.REQ_WRITE = 1; bus.REQ_WDATA = ~exp_q; bus.REQ_WMASK = 8'hFF;
        t = 0;
        while (!bus.RSP_VALID && t < 20) begin @(negedge CLK); t++; end
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (bus.RSP_VALID !== 1'b1) begin n_bad++; $display("FAIL stall_valid[%0d]: got %b expected 1", i, bus.RSP_VALID); end
            n_cmp++; if (bus.RSP_RDATA !== exp_q) begin n_bad++; $display("FAIL stall_rdata[%0d]: got %h expected %h", i, bus.RSP_RDATA, exp_q); end
            n_cmp++; if (bus.REQ_READY !== 1'b0) begin n_bad++; $display("FAIL stall_ready[%0d]: got %b expected 0", i, bus.REQ_READY); end
            n_cmp++; if (CEN !== 1'b1) begin n_bad++; $display("FAIL stall_cen[%0d]: got %b expected 1", i, CEN); end
            @(negedge CLK);
        end
        bus.REQ_VALID = 0; bus.RSP_READY = 1;
        @(negedge CLK);
        bus.RSP_READY = 0;
        n_cmp++; if (bus.RSP_VALID !== 1'b0) begin n_bad++; $display("FAIL stall_release_valid: got %b expected 0", bus.RSP_VALID); end
        n_cmp++; if (bus.REQ_READY !== 1'b1) begin n_bad++; $display("FAIL stall_release_ready: got %b expected 1", bus.REQ_READY); end
    endtask

    task automatic test_back_to_back();
        logic [6:0] as [2] = '{7'h00, 7'h7F};
        logic [7:0] ds [2];
        int acc_c [2] = '{0, 0};
        int k = 0, cyc = 0, lat, cl;
        logic seen;
        logic [7:0] q;
        ds[0] = 8'($urandom); ds[1] = 8'($urandom);
        bus.REQ_VALID = 1; bus.REQ_WRITE = 1; bus.REQ_WMASK = 8'hFF; bus.REQ_ADDR = as[0]; bus.REQ_WDATA = ds[0];
        while (k < 2 && cyc < 40) begin
            seen = bus.REQ_READY;
            @(negedge CLK); cyc++;
            if (seen) begin
                acc_c[k] = cyc;
                ref_mem[as[k]] = ds[k]; known[as[k]] = 1;
                n_cmp++; if (CEN !== 1'b0 || A !== as[k]) begin n_bad++; $display("FAIL b2b_issue[%0d]: got cen=%b a=%h expected 0/%h", k, CEN, A, as[k]); end
                k++;
                if (k < 2) begin bus.REQ_ADDR = as[k]; bus.REQ_WDATA = ds[k]; end
                else bus.REQ_VALID = 0;
            end
        end
        n_cmp++; if (k !== 2 || acc_c[1] - acc_c[0] !== 2) begin n_bad++; $display("FAIL b2b_spacing: got %0d accepts %0d cycles apart expected 2 accepts 2 apart", k, acc_c[1] - acc_c[0]); end
        repeat (2) @(negedge CLK);
        for (int i = 0; i < 2; i++) begin
            do_read(as[i], q, lat, cl);
            n_cmp++; if (q !== ds[i]) begin n_bad++; $display("FAIL b2b_read[%h]: got %h expected %h", as[i], q, ds[i]); end
        end
    endtask

    task automatic test_reset_mid();
        int t = 0, cl, lat, hits = 0;
        logic [7:0] w, q; logic g;
        do_write(7'h33, 8'($urandom), 8'hFF, cl, w, g);
        bus.REQ_VALID = 1; bus.REQ_WRITE = 0; bus.REQ_ADDR = 7'h33;
        while (!bus.REQ_READY && t < 50) begin @(negedge CLK); t++; end
        @(negedge CLK);
        RST = 1; bus.REQ_VALID = 0; bus.RSP_READY = 1;
        @(negedge CLK);
        n_cmp++; if (CEN !== 1'b1) begin n_bad++; $display("FAIL rstmid_cen: got %b expected 1", CEN); end
        n_cmp++; if (bus.RSP_VALID !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid: got %b expected 0", bus.RSP_VALID); end
        RST = 0;
        for (int i = 0; i < 10; i++) begin if (bus.RSP_VALID) hits++; @(negedge CLK); end
        bus.RSP_READY = 0;
        n_cmp++; if (hits !== 0) begin n_bad++; $display("FAIL rstmid_no_rsp: got %0d valid cycles expected 0", hits); end
        post_reset();
        do_read(7'h33, q, lat, cl);
        n_cmp++; if (q !== ref_mem[7'h33]) begin n_bad++; $display("FAIL rstmid_reread: got %h expected %h", q, ref_mem[7'h33]); end
    endtask

    task automatic test_random();
        int cl, lat;
        logic [7:0] w, q, d, m; logic g;
        logic [6:0] a;
        for (int i = 0; i < 40; i++) begin
            a = 7'($urandom);
            if ($urandom_range(0, 2) == 0 && known[a]) begin
                do_read(a, q, lat, cl);
                n_cmp++; if (q !== ref_mem[a] || lat !== 2 || cl !== 1) begin n_bad++; $display("FAIL rand_read[%0d] a=%h: got %h lat=%0d cen_lo=%0d expected %h lat=2 cen_lo=1", i, a, q, lat, cl, ref_mem[a]); end
            end else begin
                d = 8'($urandom);
                m = known[a] ? 8'($urandom) : 8'hFF;
                do_write(a, d, m, cl, w, g);
                n_cmp++; if (cl !== 1 || w !== ~m || g !== 1'b0) begin n_bad++; $display("FAIL rand_write[%0d] a=%h: got cen_lo=%0d wen=%h gwen=%b expected 1/%h/0", i, a, cl, w, g, ~m); end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin sram[i] = 8'($urandom); known[i] = 0; ref_mem[i] = 8'h00; end
        bus.REQ_VALID = 0; bus.REQ_WRITE = 0; bus.REQ_ADDR = '0;
        bus.REQ_WDATA = '0; bus.REQ_WMASK = '0; bus.RSP_READY = 0;
        test_reset();
`ifdef SRAM_INIT_EN
        test_init();
`endif
        test_basic();
        test_mask();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
        do_reset();
        test_basic();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got no finish expected completion before time limit");
        $fatal(1, "timeout");
    end
endmodule
